// File: rtl/implication_queue.sv
// Implication queue between the unit-clause evaluators and the assignment unit.
// Buffers {variable, value} implications in FIFO order, drops duplicates and flags the first contradiction.
module implication_queue #(
  parameter int NUM_VARIABLE   = 128,
  parameter int VARIABLE_INDEX = 6,
  parameter int DEPTH          = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push_valid,
  input  logic [VARIABLE_INDEX:0]   push_var,
  input  logic                      push_val,
  output logic                      push_ready,
  output logic                      pop_valid,
  output logic [VARIABLE_INDEX:0]   pop_var,
  output logic                      pop_val,
  input  logic                      pop_ready,
  output logic                      conflict,
  output logic [VARIABLE_INDEX:0]   conflict_var,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage and the per-variable value table carry no reset; pend and the
  // pointers decide what is meaningful.
  logic [VARIABLE_INDEX:0] ent_var [DEPTH];
  logic                    ent_val [DEPTH];
  logic [NUM_VARIABLE-1:0] pval;

  logic [AW:0]             head;
  logic [AW:0]             tail;
  logic [NUM_VARIABLE-1:0] pend;
  logic                    conflict_q;
  logic [VARIABLE_INDEX:0] conflict_var_q;

  logic [AW-1:0]           head_idx;
  logic [AW-1:0]           tail_idx;
  logic [VARIABLE_INDEX:0] head_var;
  logic                    head_val;
  logic                    push_fire;
  logic                    pop_fire;
  logic                    push_live;
  logic                    do_enq;
  logic                    do_conf;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign head_var = ent_var[head_idx];
  assign head_val = ent_val[head_idx];

  assign empty      = (head == tail);
  assign full       = (head_idx == tail_idx) && (head[AW] != tail[AW]);
  assign count      = tail - head;
  assign push_ready = !full && !conflict_q;
  assign pop_valid  = !empty && !conflict_q;
  assign pop_var    = pop_valid ? head_var : '0;
  assign pop_val    = pop_valid ? head_val : 1'b0;
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;

  // Classification uses start-of-cycle pend, so a push matching the head being
  // popped this cycle is seen as pending (duplicate or conflict), never re-enqueued.
  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_valid && pop_ready;
  assign push_live = push_fire && (push_var != '0);
  assign do_enq    = push_live && !pend[push_var];
  assign do_conf   = push_live && pend[push_var] && (pval[push_var] != push_val);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head           <= '0;
      tail           <= '0;
      pend           <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else begin
      if (do_enq) begin
        tail           <= tail + 1'b1;
        pend[push_var] <= 1'b1;
      end
      // An enqueued variable is never pending, so it cannot equal the popped head.
      if (pop_fire) begin
        head           <= head + 1'b1;
        pend[head_var] <= 1'b0;
      end
      if (do_conf) begin
        conflict_q     <= 1'b1;
        conflict_var_q <= push_var;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq) begin
      ent_var[tail_idx] <= push_var;
      ent_val[tail_idx] <= push_val;
      pval[push_var]    <= push_val;
    end
  end

endmodule

// File: tb/tb_implication_queue.sv
// Directed bench for implication_queue: stimulus queues expected pops, a negedge monitor compares them.
module tb_implication_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       push_valid = 1'b0;
  logic [6:0] push_var = '0;
  logic       push_val = 1'b0;
  logic       push_ready;
  logic       pop_valid;
  logic [6:0] pop_var;
  logic       pop_val;
  logic       pop_ready = 1'b0;
  logic       conflict;
  logic [6:0] conflict_var;
  logic [4:0] count;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  implication_queue #(.NUM_VARIABLE(128), .VARIABLE_INDEX(6), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_var(push_var), .push_val(push_val), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_var(pop_var), .pop_val(pop_val), .pop_ready(pop_ready),
    .conflict(conflict), .conflict_var(conflict_var),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  // Monitor: every pop the DUT will accept at the next edge must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset && !flush && pop_valid && pop_ready) begin
      logic [7:0] exp_e;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL pop_unexpected got var=%0d val=%0d, required no pop", pop_var, pop_val);
      end else begin
        exp_e = sb.pop_front();
        if ({pop_var, pop_val} !== exp_e) begin
          errors = errors + 1;
          $display("FAIL pop_order got var=%0d val=%0d, required var=%0d val=%0d",
                   pop_var, pop_val, exp_e[7:1], exp_e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      errors = errors + 1;
      $display("FAIL %s got %0d, required %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int v, input bit val, input bit exp_enq);
    push_valid = 1'b1;
    push_var   = 7'(v);
    push_val   = val;
    if (exp_enq) sb.push_back({7'(v), val});
    step();
    push_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    pop_ready = 1'b1;
    for (int i = 0; i < 64 && !empty; i++) step();
    pop_ready = 1'b0;
    check("drain_empty", int'(empty), 1);
    check("drain_scoreboard_left", sb.size(), 0);
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_push_ready", int'(push_ready), 1);
    check("rst_pop_valid", int'(pop_valid), 0);
    check("rst_pop_var", int'(pop_var), 0);
    check("rst_pop_val", int'(pop_val), 0);
    check("rst_conflict", int'(conflict), 0);
    check("rst_conflict_var", int'(conflict_var), 0);

    // Basic ordering
    push(5, 1'b1, 1'b1);
    push(9, 1'b0, 1'b1);
    push(12, 1'b1, 1'b1);
    check("three_count", int'(count), 3);
    check("three_pop_var", int'(pop_var), 5);
    drain();

    // Duplicate and null variable dropped
    push(7, 1'b1, 1'b1);
    push(7, 1'b1, 1'b0);
    push(0, 1'b1, 1'b0);
    check("dup_count", int'(count), 1);
    check("dup_conflict", int'(conflict), 0);
    drain();

    // Contradiction
    push(7, 1'b1, 1'b1);
    push(7, 1'b0, 1'b0);
    check("conf_flag", int'(conflict), 1);
    check("conf_var", int'(conflict_var), 7);
    check("conf_push_ready", int'(push_ready), 0);
    check("conf_pop_valid", int'(pop_valid), 0);
    check("conf_count_frozen", int'(count), 1);
    do_flush();
    check("flush_empty", int'(empty), 1);
    check("flush_conflict", int'(conflict), 0);
    check("flush_conflict_var", int'(conflict_var), 0);
    check("flush_push_ready", int'(push_ready), 1);

    // Fill, no bypass when full, then stream through pointer wrap
    for (int v = 1; v <= 16; v++) push(v, 1'(v), 1'b1);
    check("fill_full", int'(full), 1);
    check("fill_push_ready", int'(push_ready), 0);
    check("fill_count", int'(count), 16);
    pop_ready = 1'b1;
    push(17, 1'b1, 1'b0);
    check("full_no_bypass_count", int'(count), 15);
    for (int v = 18; v < 58; v++) push(v, 1'(v >> 1), 1'b1);
    check("stream_count", int'(count), 15);
    pop_ready = 1'b0;
    drain();

    // Same-cycle pop of head (20,1) and contradicting push
    push(20, 1'b1, 1'b1);
    pop_ready = 1'b1;
    push(20, 1'b0, 1'b0);
    pop_ready = 1'b0;
    check("headpop_conf_flag", int'(conflict), 1);
    check("headpop_conf_var", int'(conflict_var), 20);
    do_flush();

    // Same-cycle pop of head and duplicate push: dropped, pend clears
    push(20, 1'b1, 1'b1);
    pop_ready = 1'b1;
    push(20, 1'b1, 1'b0);
    pop_ready = 1'b0;
    check("headpop_dup_empty", int'(empty), 1);
    check("headpop_dup_conflict", int'(conflict), 0);
    push(20, 1'b0, 1'b1);
    check("repush_conflict", int'(conflict), 0);
    check("repush_count", int'(count), 1);
    check("repush_pop_valid", int'(pop_valid), 1);
    check("repush_pop_var", int'(pop_var), 20);
    check("repush_pop_val", int'(pop_val), 0);
    drain();

    // Flush beats same-cycle push and pop
    for (int v = 30; v < 34; v++) push(v, 1'b1, 1'b1);
    check("preflush_count", int'(count), 4);
    flush      = 1'b1;
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_var   = 7'd3;
    push_val   = 1'b1;
    step();
    flush      = 1'b0;
    push_valid = 1'b0;
    sb.delete();
    check("flush_push_count", int'(count), 0);
    check("flush_push_empty", int'(empty), 1);
    repeat (3) step();
    check("flush_push_never_popped", int'(pop_valid), 0);
    pop_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/implication_queue.md
# implication_queue

Buffers implications produced by the clause-evaluation array (implied variable, implied value, unit-clause strobe) and hands them one at a time to the variable-assignment/trail logic. Each variable's pending implication is tracked. Duplicate implications are dropped, and contradictory implications raise a sticky conflict flag for the solver controller. It sits between the unit-clause evaluators and the assignment unit, and is flushed on every backtrack.

## Interface
- NUM_VARIABLE, 128, number of variables; index 0 is reserved as "no variable".
- VARIABLE_INDEX, 6, MSB index of a variable ID (ID width = VARIABLE_INDEX+1).
- DEPTH, 16, FIFO entries (power of two, >= 2).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of queue, pending table and conflict (backtrack).
- push_valid  in  1  implication offered (driven by is_unit_clause).
- push_var  in  VARIABLE_INDEX+1  implied variable ID.
- push_val  in  1  implied value.
- push_ready  out  1  = !full && !conflict.
- pop_valid  out  1  = !empty && !conflict.
- pop_var  out  VARIABLE_INDEX+1  head entry variable (0 when !pop_valid).
- pop_val  out  1  head entry value (0 when !pop_valid).
- pop_ready  in  1  consumer accepts head.
- conflict  out  1  sticky: contradictory implication seen.
- conflict_var  out  VARIABLE_INDEX+1  variable of first contradiction.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty, full  out  1 each  occupancy flags.

## Operation
- Storage: circular buffer of DEPTH {var, val} entries, head/tail pointers with an extra wrap bit, and a pending table with pend[NUM_VARIABLE] and pval[NUM_VARIABLE].
- A push is accepted when push_valid && push_ready. A pop is accepted when pop_valid && pop_ready.
- Accepted push is classified against the pending table as it stands at the start of the cycle:
  - push_var == 0: no-op, nothing stored.
  - !pend[v]: enqueue at tail, set pend[v], pval[v] = push_val.
  - pend[v] && pval[v] == push_val: duplicate, dropped, count unchanged.
  - pend[v] && pval[v] != push_val: no enqueue. Set conflict and latch conflict_var = v.
- Accepted pop: head advances and pend[head var] clears.
- Simultaneous push and pop of the same variable:
  - the push classifies as duplicate or conflict, using start-of-cycle pend;
  - pend ends cleared.
- Simultaneous push (enqueue) and pop: count unchanged, both pointers advance.
- Full: push_ready = 0 and there is no bypass, even if a pop happens the same cycle.
- Empty: pop_valid = 0 and there is no fall-through.
- Conflict state:
  - push_ready and pop_valid are held at 0;
  - contents are frozen;
  - conflict_var holds the first offender only;
  - clears only on flush or reset.
- Priority: reset > flush > push/pop. On flush, the same cycle's push and pop are ignored.
- Pointer wrap: modulo DEPTH. full when the pointers are equal and the wrap bits differ; empty when pointers and wrap bits are equal.

## Timing
- Reset/flush effect is visible the cycle after assertion:
  - count = 0, empty = 1, full = 0;
  - push_ready = 1, pop_valid = 0, pop_var = 0, pop_val = 0;
  - conflict = 0, conflict_var = 0;
  - all pend = 0.
- Push-to-pop latency is 1 cycle. An entry enqueued at edge N is presented (pop_valid = 1) after edge N.
- pop_var and pop_val come from the registered entry array. They are stable while pop_valid && !pop_ready.
- conflict rises the cycle after the offending push edge. push_ready and pop_valid fall in that same cycle.
- Throughput is 1 push and 1 pop per cycle.
- All outputs are registered-state functions. There is no combinational path from push_* to pop_*. push_ready depends only on state.

## Test plan
- After reset, push (5,1), (9,0), (12,1) on consecutive cycles with pop_ready = 0 -> count = 3. Then pop_ready = 1 -> pops (5,1), (9,0), (12,1) in order, then empty = 1.
- Push (7,1) twice, then push (0,1) -> count = 1 and conflict = 0. A single pop yields (7,1).
- Push (7,1), then (7,0) -> next cycle conflict = 1, conflict_var = 7, push_ready = 0, pop_valid = 0. Then flush -> empty = 1, conflict = 0.
- Fill 16 distinct vars -> full = 1, push_ready = 0. Push + pop same cycle -> new var not accepted, count = 15. Continue pushes and pops across 40 entries -> FIFO order preserved through pointer wrap.
- Head (20,1) with pop_ready = 1, same-cycle push (20,0) -> conflict = 1, conflict_var = 20. Repeat with push (20,1) instead -> dropped, pend[20] clear, a later push (20,0) is enqueued without conflict.
- Flush asserted in the same cycle as push (3,1) and pop_ready = 1 with 4 entries queued -> next cycle count = 0, and (3,1) is never popped.
